image_io_sequencer: RTL and testbench

Sequences the downsampling processor end to end. It loads an input image from a byte stream into data RAM, then enables the processor and hands it the RAM port until finish. It then reads the downsampled result back out of RAM as a byte stream. It sits directly around the processor's data-memory side: it drives the processor's d_in/enable, consumes its addr_out/dout/read/write/finish, and owns the single data-RAM port.

---
 rtl/image_io_pkg.sv | 20 ++
 rtl/image_io_sequencer_mem_port_mux.sv | 35 +++
 rtl/image_io_sequencer.sv | 134 +++++++++++++
 tb/tb_image_io_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_io_pkg.sv
// Shared types and default sizing for the downsampling image I/O sequencer.
// The default sizes match the processor top so both ends agree on the RAM map.
package image_io_pkg;

  localparam int          DATA_W        = 8;
  localparam int          DEF_ADDR_W    = 16;
  localparam int          DEF_IN_BYTES  = 16384;
  localparam logic [15:0] DEF_OUT_BASE  = 16'h4000;
  localparam int          DEF_OUT_BYTES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP_ADDR,
    ST_DUMP_DATA,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/image_io_sequencer_mem_port_mux.sv
// Combinational data-RAM port select: the processor owns the port while running, the sequencer otherwise.
// Zero latency and no flow control; proc_din reads as 0 whenever the processor does not own the port.
module mem_port_mux
  import image_io_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              sel_proc,
  input  logic [ADDR_W-1:0] seq_addr,
  input  logic [DATA_W-1:0] seq_wdata,
  input  logic              seq_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_dout,
  input  logic              proc_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] proc_din
);

  always_comb begin
    mem_addr  = seq_addr;
    mem_wdata = seq_wdata;
    mem_we    = seq_we;
    proc_din  = '0;
    if (sel_proc) begin
      mem_addr  = proc_addr;
      mem_wdata = proc_dout;
      mem_we    = proc_write;
      proc_din  = mem_rdata;
    end
  end

endmodule

// File: rtl/image_io_sequencer.sv
// Loads an image into data RAM, runs the processor until finish, then streams the result out.
// Load accepts one byte per cycle; dump issues one byte per 2 cycles and holds it while out_ready is low.
module image_io_sequencer
  import image_io_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                IN_BYTES  = DEF_IN_BYTES,
  parameter logic [ADDR_W-1:0] OUT_BASE  = ADDR_W'(DEF_OUT_BASE),
  parameter int                OUT_BYTES = DEF_OUT_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              proc_enable,
  input  logic              proc_finish,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_dout,
  input  logic              proc_read,
  input  logic              proc_write,
  output logic [DATA_W-1:0] proc_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(IN_BYTES - 1);
  localparam logic [CNT_W-1:0] DUMP_LAST = CNT_W'(OUT_BYTES - 1);

  generate
    if (IN_BYTES < 1 || OUT_BYTES < 1) begin : g_bad_size
      $error("image_io_sequencer: IN_BYTES and OUT_BYTES must be at least 1");
    end
  endgenerate

  seq_state_t        state, state_nxt;
  logic [CNT_W-1:0]  load_cnt, dump_cnt;
  logic [ADDR_W-1:0] seq_addr;
  logic [DATA_W-1:0] seq_wdata;
  logic              seq_we;
  logic              load_acc, out_acc;
  logic              unused_read;

  // RAM read latency is absorbed by the processor itself.
  assign unused_read = proc_read;

  assign in_ready = (state == ST_LOAD);
  assign load_acc = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;
  assign busy     = (state == ST_LOAD) || (state == ST_RUN) ||
                    (state == ST_DUMP_ADDR) || (state == ST_DUMP_DATA);
  assign done     = (state == ST_DONE);

  // The dump address is held through DUMP_DATA with no writes, so the RAM keeps
  // returning the same byte and out_data stays stable during a stall.
  assign out_data = (state == ST_DUMP_DATA) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    seq_addr  = '0;
    seq_wdata = '0;
    seq_we    = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        seq_addr  = load_cnt[ADDR_W-1:0];
        seq_wdata = in_data;
        seq_we    = load_acc;
        if (load_acc && load_cnt == LOAD_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: if (proc_finish) state_nxt = ST_DUMP_ADDR;
      ST_DUMP_ADDR: begin
        seq_addr  = OUT_BASE + dump_cnt[ADDR_W-1:0];
        state_nxt = ST_DUMP_DATA;
      end
      ST_DUMP_DATA: begin
        seq_addr = OUT_BASE + dump_cnt[ADDR_W-1:0];
        if (out_acc) state_nxt = (dump_cnt == DUMP_LAST) ? ST_DONE : ST_DUMP_ADDR;
      end
      ST_DONE: if (start) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt    <= '0;
      dump_cnt    <= '0;
      proc_enable <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      if (state != ST_LOAD && state_nxt == ST_LOAD) load_cnt <= '0;
      else if (load_acc)                             load_cnt <= load_cnt + 1'b1;

      if (state == ST_RUN && state_nxt == ST_DUMP_ADDR) dump_cnt <= '0;
      else if (out_acc)                                 dump_cnt <= dump_cnt + 1'b1;

      proc_enable <= (state_nxt == ST_RUN);

      if (state == ST_DUMP_ADDR) out_valid <= 1'b1;
      else if (out_acc)          out_valid <= 1'b0;
    end
  end

  mem_port_mux #(.ADDR_W(ADDR_W)) u_mem_port_mux (
    .sel_proc   (state == ST_RUN),
    .seq_addr   (seq_addr),
    .seq_wdata  (seq_wdata),
    .seq_we     (seq_we),
    .proc_addr  (proc_addr),
    .proc_dout  (proc_dout),
    .proc_write (proc_write),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .proc_din   (proc_din)
  );

endmodule

// File: tb/tb_image_io_sequencer.sv
// Randomized bench for image_io_sequencer with a behavioural RAM and scripted processor.
// Expected RAM contents and output streams come from an address-indexed byte model.
module tb_image_io_sequencer;

  localparam int          IN_B  = 16;
  localparam int          OUT_B = 4;
  localparam logic [15:0] OB    = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data, proc_dout, proc_din, mem_wdata, mem_rdata;
  logic        proc_enable, proc_finish, proc_read, proc_write, mem_we, busy, done;
  logic [15:0] proc_addr, mem_addr;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  exp_mem [0:255];
  logic [7:0]  img     [0:IN_B-1];
  logic [7:0]  fixed_vals [0:OUT_B-1] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [23:0] wr_q[$];
  logic [7:0]  out_q[$];

  always #5 clk = ~clk;

  image_io_sequencer #(
    .ADDR_W(16), .IN_BYTES(IN_B), .OUT_BASE(OB), .OUT_BYTES(OUT_B)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .proc_enable(proc_enable), .proc_finish(proc_finish), .proc_addr(proc_addr),
    .proc_dout(proc_dout), .proc_read(proc_read), .proc_write(proc_write), .proc_din(proc_din),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (out_valid && out_ready) out_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid with stray start pulses
  task automatic load_image(input int mode);
    int   idx, cyc;
    logic acc;
    for (int i = 0; i < IN_B; i++) begin
      img[i]     = 8'($urandom);
      exp_mem[i] = img[i];
    end
    wr_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("load_entry_in_ready", in_ready, 1);
    check("load_entry_done", done, 0);
    check("load_entry_busy", busy, 1);
    idx = 0;
    cyc = 0;
    while (idx < IN_B && cyc < 400) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ~cyc[0];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? img[idx] : 8'($urandom);
      start   = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("load_count", idx, IN_B);
    check("run_in_ready", in_ready, 0);
    check("run_proc_enable", proc_enable, 1);
    check("load_nwrites", wr_q.size(), IN_B);
    for (int i = 0; i < wr_q.size() && i < IN_B; i++) begin
      check("load_waddr", wr_q[i][23:8], i);
      check("load_wdata", wr_q[i][7:0], img[i]);
    end
  endtask

  task automatic run_proc(input bit fixed);
    logic [7:0] v;
    int         r;
    wr_q.delete();
    for (int k = 0; k < OUT_B; k++) begin
      v          = fixed ? fixed_vals[k] : 8'($urandom);
      proc_addr  = OB + 16'(k);
      proc_dout  = v;
      proc_write = 1'b1;
      exp_mem[OB + k] = v;
      @(posedge clk); #1;
      proc_write = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    check("run_nwrites", wr_q.size(), OUT_B);
    for (int i = 0; i < wr_q.size() && i < OUT_B; i++) begin
      check("run_waddr", wr_q[i][23:8], OB + i);
      check("run_wdata", wr_q[i][7:0], exp_mem[OB + i]);
    end
    r         = $urandom_range(0, IN_B - 1);
    proc_read = 1'b1;
    proc_addr = 16'(r);
    @(posedge clk); #1;
    check("run_proc_din", proc_din, exp_mem[r]);
    proc_read   = 1'b0;
    proc_finish = 1'b1;
    proc_addr   = 16'($urandom);
    @(posedge clk); #1;
    check("finish_proc_enable", proc_enable, 0);
    check("dump_proc_din", proc_din, 0);
    check("dump_busy", busy, 1);
  endtask

  // mode 0: always ready, 1: 5-cycle stall on the second byte, 2: random ready with stray start pulses
  task automatic dump(input int mode);
    int          got, cyc, stall;
    logic [7:0]  held;
    logic [15:0] held_addr;
    bit          stalled;
    out_q.delete();
    got = 0; cyc = 0; stall = 0; stalled = 0;
    held = '0; held_addr = '0;
    while (got < OUT_B && cyc < 300) begin
      @(posedge clk); #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(got == 1 && stall < 5);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      if (out_valid) begin
        if (stalled) begin
          check("stall_hold_data", out_data, held);
          check("stall_hold_addr", mem_addr, held_addr);
        end
        check("dump_we", mem_we, 0);
        if (out_ready) begin
          got++;
          stalled = 0;
        end else begin
          stalled   = 1;
          held      = out_data;
          held_addr = mem_addr;
          stall++;
        end
      end
      cyc++;
    end
    @(posedge clk); #1;
    out_ready   = 1'b0;
    start       = 1'b0;
    proc_finish = 1'b0;
    check("dump_count", got, OUT_B);
    if (mode == 0) check("dump_cycles", cyc, 2 * OUT_B - 1);
    if (mode == 1) check("stall_cycles", stall, 5);
    check("done", done, 1);
    check("done_busy", busy, 0);
    check("done_out_valid", out_valid, 0);
    check("dump_nbytes", out_q.size(), OUT_B);
    for (int i = 0; i < out_q.size() && i < OUT_B; i++)
      check("dump_data", out_q[i], exp_mem[OB + i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    proc_finish = 1'b0; proc_addr = '0; proc_dout = '0; proc_read = 1'b0; proc_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_proc_enable", proc_enable, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_proc_din", proc_din, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_image(0); run_proc(1'b1); dump(1);
    load_image(1); run_proc(1'b0); dump(0);
    load_image(2); run_proc(1'b0); dump(2);

    // Reset in the middle of RUN with the processor still asserting write.
    load_image(0);
    proc_write = 1'b1;
    proc_addr  = OB;
    proc_dout  = 8'h5A;
    exp_mem[OB] = 8'h5A;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_proc_enable", proc_enable, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_done", done, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    proc_write = 1'b0;
    load_image(2); run_proc(1'b0); dump(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
